// File: rtl/replica_pkg.sv
// Shared types and sizing for the replica array and its host-side table loader.
package replica_pkg;

    localparam int city_num     = 8;
    localparam int city_num_log = 3;

    typedef logic [7:0] distance_data_t;

    typedef enum logic [2:0] {
        IDLE,
        DIAG,
        LOAD_A,
        LOAD_B,
        DONE
    } loader_state_t;

endpackage

// File: rtl/tri_index_counter.sv
// Walks the strict upper triangle (i<j) of an ncity x ncity table in row-major order.
module tri_index_counter
    import replica_pkg::*;
#(
    parameter int ncity = city_num
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    step,
    output logic [city_num_log-1:0] i,
    output logic [city_num_log-1:0] j,
    output logic                    last
);

    localparam int W = city_num_log;
    localparam logic [W-1:0] LAST_IDX = W'(ncity - 1);
    localparam logic [W-1:0] PEN_IDX  = W'(ncity - 2);

    logic [W-1:0] i_q, i_d;
    logic [W-1:0] j_q, j_d;

    assign i    = i_q;
    assign j    = j_q;
    assign last = (i_q == PEN_IDX) && (j_q == LAST_IDX);

    // Stepping past the final pair returns to (0,1) instead of overflowing j.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clear || (step && last)) begin
            i_d = '0;
            j_d = W'(1);
        end else if (step) begin
            if (j_q < LAST_IDX) begin
                j_d = j_q + 1'b1;
            end else begin
                i_d = i_q + 1'b1;
                j_d = i_q + W'(2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            i_q <= '0;
            j_q <= W'(1);
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

endmodule

// File: rtl/distance_loader.sv
// Expands an upper-triangle distance stream into a symmetric table on the node broadcast bus.
//
// state  | meaning
// IDLE   | waiting for start
// DIAG   | writing zero to {d,d}, one entry per cycle
// LOAD_A | s_ready high, waiting for the next (i,j) distance
// LOAD_B | writing the mirrored {j,i} entry, then advancing (i,j)
// DONE   | one-cycle done pulse
module distance_loader
    import replica_pkg::*;
#(
    parameter int ncity = city_num
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  distance_data_t            s_data,
    output logic                      busy,
    output logic                      done,
    output logic                      distance_write,
    output logic [city_num_log*2-1:0] distance_w_addr,
    output distance_data_t            distance_w_data
);

    localparam int W = city_num_log;
    localparam logic [W-1:0] LAST_IDX = W'(ncity - 1);

    loader_state_t   state_q, state_d;
    logic [W-1:0]    d_q, d_d;
    distance_data_t  data_q, data_d;
    logic            write_q, write_d;
    logic [2*W-1:0]  addr_q, addr_d;
    distance_data_t  wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            tri_clear;
    logic            tri_step;
    logic [W-1:0]    tri_i;
    logic [W-1:0]    tri_j;
    logic            tri_last;

    tri_index_counter #(
        .ncity (ncity)
    ) u_tri (
        .clk   (clk),
        .reset (reset),
        .clear (tri_clear),
        .step  (tri_step),
        .i     (tri_i),
        .j     (tri_j),
        .last  (tri_last)
    );

    assign s_ready         = (state_q == LOAD_A);
    assign busy            = busy_q;
    assign done            = done_q;
    assign distance_write  = write_q;
    assign distance_w_addr = addr_q;
    assign distance_w_data = wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            data_q  <= data_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = DIAG;
                DIAG:    if (d_q == LAST_IDX) state_d = LOAD_A;
                LOAD_A:  if (s_valid) state_d = LOAD_B;
                LOAD_B:  state_d = tri_last ? DONE : LOAD_A;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Write strobes are registered, so each state's write lands one cycle after it is decided.
    always_comb begin
        d_d       = d_q;
        data_d    = data_q;
        write_d   = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        tri_clear = 1'b0;
        tri_step  = 1'b0;
        if (abort) begin
            d_d       = '0;
            data_d    = '0;
            tri_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    d_d       = '0;
                    tri_clear = 1'b1;
                end
                DIAG: begin
                    write_d   = 1'b1;
                    addr_d    = {d_q, d_q};
                    d_d       = (d_q == LAST_IDX) ? '0 : d_q + 1'b1;
                    tri_clear = 1'b1;
                end
                LOAD_A: begin
                    if (s_valid) begin
                        data_d  = s_data;
                        write_d = 1'b1;
                        addr_d  = {tri_i, tri_j};
                        wdata_d = s_data;
                    end
                end
                LOAD_B: begin
                    write_d  = 1'b1;
                    addr_d   = {tri_j, tri_i};
                    wdata_d  = data_q;
                    tri_step = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_distance_loader.sv
// Scoreboard bench for distance_loader at ncity=4 and ncity=2.
module tb_distance_loader;
    import replica_pkg::*;

    localparam int W = city_num_log;

    typedef struct packed {
        logic [2*W-1:0] addr;
        distance_data_t data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic           start4, abort4, s_valid4, s_ready4, busy4, done4, write4;
    distance_data_t s_data4, wdata4;
    logic [2*W-1:0] addr4;

    logic           start2, abort2, s_valid2, s_ready2, busy2, done2, write2;
    distance_data_t s_data2, wdata2;
    logic [2*W-1:0] addr2;

    distance_loader #(.ncity(4)) u_dut4 (
        .clk             (clk),
        .reset           (reset),
        .start           (start4),
        .abort           (abort4),
        .s_valid         (s_valid4),
        .s_ready         (s_ready4),
        .s_data          (s_data4),
        .busy            (busy4),
        .done            (done4),
        .distance_write  (write4),
        .distance_w_addr (addr4),
        .distance_w_data (wdata4)
    );

    distance_loader #(.ncity(2)) u_dut2 (
        .clk             (clk),
        .reset           (reset),
        .start           (start2),
        .abort           (abort2),
        .s_valid         (s_valid2),
        .s_ready         (s_ready2),
        .s_data          (s_data2),
        .busy            (busy2),
        .done            (done2),
        .distance_write  (write2),
        .distance_w_addr (addr2),
        .distance_w_data (wdata2)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t exp4_q[$];
    wr_t exp2_q[$];
    int  wr4_cnt = 0, done4_cnt = 0;
    int  wr2_cnt = 0, done2_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input int r, input int c, input int dat);
        wr_t e;
        e.addr = {W'(r), W'(c)};
        e.data = distance_data_t'(dat);
        exp4_q.push_back(e);
    endtask

    task automatic push2(input int r, input int c, input int dat);
        wr_t e;
        e.addr = {W'(r), W'(c)};
        e.data = distance_data_t'(dat);
        exp2_q.push_back(e);
    endtask

    always @(negedge clk) begin : mon4
        wr_t e;
        if (write4) begin
            check_val("wr4_expected", 32'(exp4_q.size() > 0), 32'd1);
            if (exp4_q.size() > 0) begin
                e = exp4_q.pop_front();
                check_val("wr4_addr", 32'(addr4), 32'(e.addr));
                check_val("wr4_data", 32'(wdata4), 32'(e.data));
            end
            wr4_cnt++;
        end
        if (done4) done4_cnt++;
    end

    always @(negedge clk) begin : mon2
        wr_t e;
        if (write2) begin
            check_val("wr2_expected", 32'(exp2_q.size() > 0), 32'd1);
            if (exp2_q.size() > 0) begin
                e = exp2_q.pop_front();
                check_val("wr2_addr", 32'(addr2), 32'(e.addr));
                check_val("wr2_data", 32'(wdata2), 32'(e.data));
            end
            wr2_cnt++;
        end
        if (done2) done2_cnt++;
    end

    // Starts a load on the ncity=4 loader and feeds n entries (data 10,11,...).
    // Returns one cycle after the n-th acceptance, i.e. while the DUT is in LOAD_B.
    task automatic feed4(input int n, input bit toggle, input bit poke);
        int k, ti, tj, cyc;
        wr4_cnt   = 0;
        done4_cnt = 0;
        for (int d = 0; d < 4; d++) push4(d, d, 0);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        k = 0; ti = 0; tj = 1; cyc = 0;
        while (k < n && cyc < 200) begin
            s_valid4 = toggle ? (cyc % 2 == 1) : 1'b1;
            s_data4  = distance_data_t'(10 + k);
            start4   = poke && (cyc == 1 || cyc == 6);
            @(negedge clk);
            if (cyc == 0) check_val("busy_after_start", 32'(busy4), 32'd1);
            if (cyc < 4) check_val("s_ready_in_diag", 32'(s_ready4), 32'd0);
            if (cyc == (toggle ? 6 : 5)) check_val("s_ready_in_load_b", 32'(s_ready4), 32'd0);
            if (toggle && cyc == 5) check_val("no_write_while_wait", 32'(write4), 32'd0);
            if (s_valid4 && s_ready4) begin
                push4(ti, tj, 10 + k);
                push4(tj, ti, 10 + k);
                k++;
                if (tj == 3) begin
                    ti++;
                    tj = ti + 1;
                end else begin
                    tj++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid4 = 1'b0;
        start4   = 1'b0;
        check_val("entries_accepted", 32'(k), 32'(n));
    endtask

    task automatic run_load4(input bit toggle, input bit poke);
        int cyc;
        feed4(6, toggle, poke);
        cyc = 0;
        while (done4_cnt == 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        check_val("busy_after_done", 32'(busy4), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("done_pulses", 32'(done4_cnt), 32'd1);
        check_val("write_count", 32'(wr4_cnt), 32'd16);
        check_val("exp4_drained", 32'(exp4_q.size()), 32'd0);
    endtask

    initial begin
        int acc, cyc;
        reset    = 1'b0;
        start4   = 1'b0; abort4 = 1'b0; s_valid4 = 1'b0; s_data4 = '0;
        start2   = 1'b0; abort2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        s_valid4 = 1'b1;
        @(negedge clk);
        check_val("rst_s_ready", 32'(s_ready4), 32'd0);
        check_val("rst_busy", 32'(busy4), 32'd0);
        check_val("rst_done", 32'(done4), 32'd0);
        check_val("rst_write", 32'(write4), 32'd0);
        check_val("rst_addr", 32'(addr4), 32'd0);
        check_val("rst_data", 32'(wdata4), 32'd0);
        check_val("rst_busy2", 32'(busy2), 32'd0);
        @(posedge clk); #1;
        s_valid4 = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;

        // Full load, s_valid held high, then with toggling s_valid, then with start pokes.
        run_load4(1'b0, 1'b0);
        run_load4(1'b1, 1'b0);
        run_load4(1'b0, 1'b1);

        // Abort after three entries; the pending mirrored write must not appear.
        feed4(3, 1'b0, 1'b0);
        abort4 = 1'b1;
        void'(exp4_q.pop_back());
        @(posedge clk); #1;
        abort4 = 1'b0;
        @(negedge clk);
        check_val("abort_write", 32'(write4), 32'd0);
        check_val("abort_busy", 32'(busy4), 32'd0);
        check_val("abort_s_ready", 32'(s_ready4), 32'd0);
        check_val("abort_done", 32'(done4), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("abort_no_done", 32'(done4_cnt), 32'd0);
        check_val("abort_write_count", 32'(wr4_cnt), 32'd9);
        check_val("abort_exp_drained", 32'(exp4_q.size()), 32'd0);
        run_load4(1'b0, 1'b0);

        // Reset while in LOAD_B.
        feed4(1, 1'b0, 1'b0);
        reset = 1'b0;
        void'(exp4_q.pop_back());
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_write", 32'(write4), 32'd0);
        check_val("mid_rst_busy", 32'(busy4), 32'd0);
        check_val("mid_rst_s_ready", 32'(s_ready4), 32'd0);
        check_val("mid_rst_addr", 32'(addr4), 32'd0);
        check_val("mid_rst_data", 32'(wdata4), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", 32'(done4_cnt), 32'd0);
        check_val("mid_rst_write_count", 32'(wr4_cnt), 32'd5);
        check_val("mid_rst_exp_drained", 32'(exp4_q.size()), 32'd0);
        run_load4(1'b0, 1'b0);

        // ncity=2: one entry, a held s_valid afterwards stays unaccepted.
        push2(0, 0, 0);
        push2(1, 1, 0);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2   = 1'b0;
        s_valid2 = 1'b1;
        s_data2  = 8'h7F;
        acc = 0;
        cyc = 0;
        while (done2_cnt == 0 && cyc < 40) begin
            @(negedge clk);
            if (s_valid2 && s_ready2) begin
                acc++;
                push2(0, 1, 'h7F);
                push2(1, 0, 'h7F);
            end
            @(posedge clk); #1;
            cyc++;
        end
        repeat (5) begin
            @(negedge clk);
            if (s_valid2 && s_ready2) acc++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_val("n2_s_ready_idle", 32'(s_ready2), 32'd0);
        check_val("n2_accepted", 32'(acc), 32'd1);
        check_val("n2_write_count", 32'(wr2_cnt), 32'd4);
        check_val("n2_done_pulses", 32'(done2_cnt), 32'd1);
        check_val("n2_exp_drained", 32'(exp2_q.size()), 32'd0);
        s_valid2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
